mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Parametrised MEM-stage data-memory interface for the pipelined core.
//   Adds sub-word loads/stores, byte enables, load sign/zero extension, alignment checking and a
//   req/ack handshake to a variable-latency data memory. While an access is outstanding the
//   pipeline is held through stall. A timeout aborts accesses that are never acknowledged.
// PARAMETERS
//   XLEN     32  datapath width; legal values 32 or 64
//   ADDR_W   32  data-memory address width
//   TIMEOUT  15  BUSY cycles without ack before abort (1..255)
// PORTS
//   clk              in   1         rising-edge clock
//   rst              in   1         synchronous, active-high reset
//   mem_read         in   1         load request from EX/MEM; held stable while stall=1
//   mem_write        in   1         store request; takes priority when mem_read is also 1
//   mem_size         in   2         00 byte, 01 half, 10 word, 11 dword (dword legal only when XLEN=64)
//   mem_unsigned     in   1         1 = zero-extend load, 0 = sign-extend load
//   alu_result       in   ADDR_W    effective byte address
//   rt_forward_value in   XLEN      store data, in the low bits
//   stall            out  1         holds the pipeline (combinational)
//   dmem_req         out  1         access request, registered
//   dmem_we          out  1         1 = write, registered
//   dmem_addr        out  ADDR_W    latched byte address
//   dmem_be          out  XLEN/8    byte-lane enables
//   dmem_wdata       out  XLEN      store data replicated across lanes
//   dmem_ack         in   1         access complete; dmem_rdata valid when read
//   dmem_rdata       in   XLEN      full-width read data
//   mem_data_out     out  XLEN      extended load result, registered
//   load_valid       out  1         1-cycle pulse: mem_data_out updated
//   misalign_err     out  1         1-cycle pulse: misaligned access dropped
//   timeout_err      out  1         1-cycle pulse: access aborted
// BEHAVIOUR
//   Reset
//   - state=IDLE; wait counter=0.
//   - All registered outputs are 0; stall=0.
//   - Reset mid-access: the access is abandoned, dmem_req=0 next cycle, and no load_valid or error is raised.
//   Alignment
//   - Legal when addr mod size_bytes = 0.
//   - Illegal: half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0, and dword when XLEN=32.
//   Access flow (FSM IDLE/BUSY)
//   - IDLE, (mem_read|mem_write) and aligned:
//       - stall=1;
//       - latch addr, be, wdata and we;
//       - next state BUSY, with dmem_req=1.
//   - IDLE, misaligned:
//       - no request, stall=0;
//       - misalign_err=1 the next cycle.
//   - BUSY, dmem_ack=0:
//       - stall=1; the counter increments;
//       - when the counter reaches TIMEOUT-1 with no ack, that cycle is the last: next cycle timeout_err=1, dmem_req=0, state IDLE;
//       - stall=0 in the final cycle so the pipeline advances.
//   - BUSY, dmem_ack=1:
//       - stall=0; state IDLE; dmem_req=0 next cycle; counter cleared;
//       - for a read, mem_data_out and load_valid=1 are registered the next cycle;
//       - ack in the same cycle as the timeout limit: ack wins.
//   - dmem_ack while IDLE is ignored.
//   - Minimum access time: 2 cycles (request cycle plus ack cycle). Load data is visible the cycle after ack.
//   Lanes (lane = addr[log2(XLEN/8)-1:0])
//   - Byte-enable masks, shifted by lane:
//       - byte 1<<lane; half 2'b11<<lane; word 4'hF<<lane;
//       - dword or (word with XLEN=32): all ones.
//   - dmem_wdata: the low size bytes of rt_forward_value replicated to every lane.
//   - Load: extract the size bytes at the lane; extend to XLEN per mem_unsigned.
//   Outputs and stability
//   - mem_data_out holds its value between loads.
//   - Stores never pulse load_valid.
//   - dmem_addr, dmem_be, dmem_wdata and dmem_we are stable while dmem_req=1.
// TESTING
//   - XLEN=32: load byte, addr 0x103, rdata 0x80FF_1234, unsigned=0, ack after 3 BUSY cycles
//       -> stall for 4 cycles; be=4'b1000; mem_data_out=0xFFFF_FF80; load_valid one pulse.
//   - Store half, addr 0x202, data 0x0000_BEEF
//       -> be=4'b1100, wdata=0xBEEF_BEEF, we=1; no load_valid.
//   - Load word, addr 0x101
//       -> misalign_err pulse; dmem_req stays 0; stall stays 0.
//   - TIMEOUT=4 with ack never asserted
//       -> 4 BUSY cycles; timeout_err pulse; dmem_req falls; state returns to IDLE.
//   - mem_read and mem_write both 1
//       -> write performed.
//   - rst asserted in BUSY
//       -> dmem_req=0 next cycle; a following ack has no effect.
//   - XLEN=64, load dword unsigned, addr 0x8
//       -> be=8'hFF; mem_data_out = rdata.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
// req/we/addr/be/wdata are held stable while req=1; ack=1 completes the access and qualifies rdata on reads.
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              ack;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: sub-word loads/stores, byte enables, load extension,
// alignment checking and a req/ack handshake with a timeout abort; holds the pipeline via stall_o.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [ADDR_W-1:0] alu_result_i,
  input  logic [XLEN-1:0]   rt_forward_value_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   mem_data_out_o,
  output logic              load_valid_o,
  output logic              misalign_err_o,
  output logic              timeout_err_o,
  output logic              state_o,
  mem_access_unit_if.master dmem
);
  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q, be_new;
  logic [XLEN-1:0]   wdata_q, wdata_new, dout_q, shifted, ld_ext;
  logic              lv_q, mis_q, to_q;
  logic              misaligned, start, done, abort, mis_d, stall;
  logic [LANE_W-1:0] lane;

  assign lane = alu_result_i[LANE_W-1:0];

  always_comb begin
    misaligned = 1'b0;
    be_new     = '1;
    wdata_new  = rt_forward_value_i;
    case (mem_size_i)
      2'b00: begin
        be_new    = NB'(1) << lane;
        wdata_new = {NB{rt_forward_value_i[7:0]}};
      end
      2'b01: begin
        misaligned = alu_result_i[0];
        be_new     = NB'(3) << lane;
        wdata_new  = {NB/2{rt_forward_value_i[15:0]}};
      end
      2'b10: begin
        misaligned = |alu_result_i[1:0];
        be_new     = NB'(15) << lane;
        wdata_new  = {XLEN/32{rt_forward_value_i[31:0]}};
      end
      default: misaligned = (XLEN == 32) || (|alu_result_i[2:0]);
    endcase
  end

  // Load data arrives full-width; bring the addressed lane down to bit 0 before extending.
  always_comb begin
    shifted = dmem.rdata >> {addr_q[LANE_W-1:0], 3'b000};
    case (size_q)
      2'b00:   ld_ext = uns_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'b01:   ld_ext = uns_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'b10:   ld_ext = uns_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read_i || mem_write_i) begin
          if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            stall   = 1'b1;
            start   = 1'b1;
            state_d = BUSY;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        // Ack in the limit cycle completes normally rather than aborting.
        if (dmem.ack) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      lv_q    <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      to_q    <= abort;
      lv_q    <= done && !we_q;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= mem_write_i;
        uns_q   <= mem_unsigned_i;
        size_q  <= mem_size_i;
        addr_q  <= alu_result_i;
        be_q    <= be_new;
        wdata_q <= wdata_new;
      end
      if (done || abort) req_q <= 1'b0;
      if (done && !we_q) dout_q <= ld_ext;
    end
  end

  assign stall_o        = stall && !rst;
  assign mem_data_out_o = dout_q;
  assign load_valid_o   = lv_q;
  assign misalign_err_o = mis_q;
  assign timeout_err_o  = to_q;
  assign state_o        = state_q[0];
  assign dmem.req       = req_q;
  assign dmem.we        = we_q;
  assign dmem.addr      = addr_q;
  assign dmem.be        = be_q;
  assign dmem.wdata     = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit instance with TIMEOUT=4 and a 64-bit instance, driven
// through a small memory responder; load results go through an expected-value queue.
module tb_mem_access_unit;
  logic clk, rst;
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  // 32-bit instance
  logic        rd32, wr32, un32, stall32, lv32, mis32, to32, st32;
  logic [1:0]  sz32;
  logic [31:0] addr32, wd32, dout32;
  mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) bus32 ();

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst), .mem_read_i(rd32), .mem_write_i(wr32), .mem_size_i(sz32),
    .mem_unsigned_i(un32), .alu_result_i(addr32), .rt_forward_value_i(wd32),
    .stall_o(stall32), .mem_data_out_o(dout32), .load_valid_o(lv32),
    .misalign_err_o(mis32), .timeout_err_o(to32), .state_o(st32), .dmem(bus32.master)
  );

  // 64-bit instance
  logic        rd64, wr64, un64, stall64, lv64, mis64, to64, st64;
  logic [1:0]  sz64;
  logic [31:0] addr64;
  logic [63:0] wd64, dout64;
  mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(15)) u64 (
    .clk(clk), .rst(rst), .mem_read_i(rd64), .mem_write_i(wr64), .mem_size_i(sz64),
    .mem_unsigned_i(un64), .alu_result_i(addr64), .rt_forward_value_i(wd64),
    .stall_o(stall64), .mem_data_out_o(dout64), .load_valid_o(lv64),
    .misalign_err_o(mis64), .timeout_err_o(to64), .state_o(st64), .dmem(bus64.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model32(input logic [1:0] sz, input logic un,
                                          input logic [31:0] addr, input logic [31:0] rdat);
    logic [31:0] s;
    s = rdat >> (8 * addr[1:0]);
    case (sz)
      2'd0:    return un ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'd1:    return un ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Drives one 32-bit access; the memory acks in busy cycle ack_after+1 (never if ack_after<0).
  // The request is withdrawn after the first clock edge at which stall was low.
  task automatic run32(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                       input int ack_after,
                       output int stall_n, output int busy_n, output int lv_n, output int mis_n,
                       output int to_n, output logic [3:0] be_s, output logic [31:0] wd_s,
                       output logic we_s, output logic [31:0] addr_s, output logic [31:0] dout);
    bit released;
    int post;
    logic st;
    stall_n = 0; busy_n = 0; lv_n = 0; mis_n = 0; to_n = 0;
    be_s = '0; wd_s = '0; we_s = 1'b0; addr_s = '0; dout = '0;
    released = 0; post = 0;
    @(negedge clk);
    rd32 = rd; wr32 = wr; sz32 = sz; un32 = un; addr32 = addr; wd32 = wd;
    bus32.rdata = rdat; bus32.ack = 1'b0;
    for (int c = 0; c < 40 && post < 3; c++) begin
      if (bus32.req) begin
        busy_n++;
        be_s = bus32.be; wd_s = bus32.wdata; we_s = bus32.we; addr_s = bus32.addr;
        bus32.ack = (busy_n == ack_after + 1);
      end else begin
        bus32.ack = 1'b0;
      end
      #1;
      st = stall32;
      if (!released && st) stall_n++;
      @(posedge clk); #1;
      if (lv32)  begin lv_n++; dout = dout32; end
      if (mis32) mis_n++;
      if (to32)  to_n++;
      @(negedge clk);
      if (released) post++;
      else if (!st) begin released = 1; rd32 = 1'b0; wr32 = 1'b0; end
    end
    bus32.ack = 1'b0;
    n_checks++;
    if (!released) begin
      n_fail++;
      $display("FAIL run32_bound: stall never released within 40 cycles (got 0, expected 1)");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus32.req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus32.req); end
    n_checks++; if (bus32.we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", bus32.we); end
    n_checks++; if (bus32.addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus32.addr); end
    n_checks++; if (bus32.be !== 4'h0) begin n_fail++; $display("FAIL rst_be: got %h expected 0", bus32.be); end
    n_checks++; if (bus32.wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0", bus32.wdata); end
    n_checks++; if (dout32 !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h expected 0", dout32); end
    n_checks++; if ({lv32, mis32, to32, stall32, st32} !== 5'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b expected 00000", {lv32, mis32, to32, stall32, st32});
    end
    n_checks++; if ({bus64.req, lv64, stall64, dout64} !== 67'h0) begin
      n_fail++; $display("FAIL rst_u64: got req=%b lv=%b stall=%b dout=%h expected all 0", bus64.req, lv64, stall64, dout64);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_byte();
    int sn, bn, ln, mn, tn; logic [3:0] be; logic [31:0] wd, ad, dout; logic we;
    exp_q.push_back(64'hFFFF_FF80);
    run32(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_1234, 3, sn, bn, ln, mn, tn, be, wd, we, ad, dout);
    n_checks++; if (sn != 4) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d expected 4", sn); end
    n_checks++; if (bn != 4) begin n_fail++; $display("FAIL lb_busy_cycles: got %0d expected 4", bn); end
    n_checks++; if (be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b expected 1000", be); end
    n_checks++; if (ad !== 32'h103) begin n_fail++; $display("FAIL lb_addr: got %h expected 103", ad); end
    n_checks++; if (ln != 1) begin n_fail++; $display("FAIL lb_load_valid: got %0d pulses expected 1", ln); end
    n_checks++; if (tn != 0) begin n_fail++; $display("FAIL lb_ack_beats_timeout: got %0d timeout pulses expected 0", tn); end
    if (ln > 0 && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++; if (dout !== exp_v[31:0]) begin n_fail++; $display("FAIL lb_data: got %h expected %h", dout, exp_v[31:0]); end
    end
    repeat (3) @(negedge clk);
    n_checks++; if (dout32 !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_hold: got %h expected ffffff80", dout32); end
  endtask

  task automatic test_loads_random();
    int sn, bn, ln, mn, tn, aa; logic [3:0] be; logic [31:0] wd, ad, dout, addr, rdat; logic we, un;
    logic [1:0] sz;
    for (int i = 0; i < 10; i++) begin
      sz = 2'($urandom_range(0, 2));
      un = 1'($urandom_range(0, 1));
      rdat = $urandom;
      aa = $urandom_range(0, 2);
      addr = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      if (sz == 2'd0) addr[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'd1) addr[1] = 1'($urandom_range(0, 1));
      exp_q.push_back({32'h0, model32(sz, un, addr, rdat)});
      run32(1, 0, sz, un, addr, 32'h0, rdat, aa, sn, bn, ln, mn, tn, be, wd, we, ad, dout);
      n_checks++; if (sn != aa + 1) begin n_fail++; $display("FAIL rl_stall_%0d: got %0d expected %0d", i, sn, aa + 1); end
      n_checks++; if (ln != 1) begin n_fail++; $display("FAIL rl_valid_%0d: got %0d expected 1", i, ln); end
      if (ln > 0 && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++; if (dout !== exp_v[31:0]) begin
          n_fail++; $display("FAIL rl_data_%0d: got %h expected %h (sz=%0d un=%b addr=%h rdata=%h)", i, dout, exp_v[31:0], sz, un, addr, rdat);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_store_half();
    int sn, bn, ln, mn, tn; logic [3:0] be; logic [31:0] wd, ad, dout, held; logic we;
    held = dout32;
    run32(0, 1, 2'd1, 0, 32'h202, 32'h0000_BEEF, 32'h0, 1, sn, bn, ln, mn, tn, be, wd, we, ad, dout);
    n_checks++; if (be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b expected 1100", be); end
    n_checks++; if (wd !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h expected beefbeef", wd); end
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b expected 1", we); end
    n_checks++; if (ln != 0) begin n_fail++; $display("FAIL sh_no_load_valid: got %0d expected 0", ln); end
    n_checks++; if (dout32 !== held) begin n_fail++; $display("FAIL sh_dout_hold: got %h expected %h", dout32, held); end
  endtask

  task automatic test_misalign();
    int sn, bn, ln, mn, tn; logic [3:0] be; logic [31:0] wd, ad, dout; logic we;
    logic [1:0] szs[3]; logic [31:0] ads[3];
    szs[0] = 2'd2; ads[0] = 32'h101;
    szs[1] = 2'd1; ads[1] = 32'h203;
    szs[2] = 2'd3; ads[2] = 32'h200;
    for (int i = 0; i < 3; i++) begin
      run32(1, 0, szs[i], 0, ads[i], 32'h0, 32'hFFFF_FFFF, 0, sn, bn, ln, mn, tn, be, wd, we, ad, dout);
      n_checks++; if (mn != 1) begin n_fail++; $display("FAIL mis_pulse_%0d: got %0d expected 1", i, mn); end
      n_checks++; if (bn != 0) begin n_fail++; $display("FAIL mis_req_%0d: got %0d req cycles expected 0", i, bn); end
      n_checks++; if (sn != 0 || ln != 0) begin n_fail++; $display("FAIL mis_stall_%0d: got stall=%0d lv=%0d expected 0 0", i, sn, ln); end
    end
  endtask

  task automatic test_timeout();
    int sn, bn, ln, mn, tn; logic [3:0] be; logic [31:0] wd, ad, dout; logic we;
    run32(1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h1234_5678, -1, sn, bn, ln, mn, tn, be, wd, we, ad, dout);
    n_checks++; if (bn != 4) begin n_fail++; $display("FAIL to_busy: got %0d expected 4", bn); end
    n_checks++; if (tn != 1) begin n_fail++; $display("FAIL to_pulse: got %0d expected 1", tn); end
    n_checks++; if (sn != 4) begin n_fail++; $display("FAIL to_stall: got %0d expected 4", sn); end
    n_checks++; if (ln != 0 || bus32.req !== 1'b0 || st32 !== 1'b0) begin
      n_fail++; $display("FAIL to_idle: got lv=%0d req=%b state=%b expected 0 0 0", ln, bus32.req, st32);
    end
  endtask

  task automatic test_rd_wr_both();
    int sn, bn, ln, mn, tn; logic [3:0] be; logic [31:0] wd, ad, dout; logic we;
    run32(1, 1, 2'd0, 0, 32'h401, 32'h0000_00A5, 32'h0, 0, sn, bn, ln, mn, tn, be, wd, we, ad, dout);
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL rw_we: got %b expected 1", we); end
    n_checks++; if (wd !== 32'hA5A5_A5A5 || be !== 4'b0010) begin
      n_fail++; $display("FAIL rw_lanes: got wdata=%h be=%b expected a5a5a5a5 0010", wd, be);
    end
    n_checks++; if (ln != 0) begin n_fail++; $display("FAIL rw_no_load_valid: got %0d expected 0", ln); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    rd32 = 1'b1; wr32 = 1'b0; sz32 = 2'd2; un32 = 1'b0; addr32 = 32'h500; bus32.ack = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus32.req !== 1'b1) begin n_fail++; $display("FAIL rb_req_up: got %b expected 1", bus32.req); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus32.req !== 1'b0 || stall32 !== 1'b0) begin
      n_fail++; $display("FAIL rb_req_drop: got req=%b stall=%b expected 0 0", bus32.req, stall32);
    end
    @(negedge clk);
    rst = 1'b0; rd32 = 1'b0; bus32.ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_checks++; if ({lv32, mis32, to32, bus32.req, st32} !== 5'b0) begin
        n_fail++; $display("FAIL rb_stray_ack_%0d: got lv,mis,to,req,state=%b expected 00000", c, {lv32, mis32, to32, bus32.req, st32});
      end
    end
    @(negedge clk);
    bus32.ack = 1'b0;
  endtask

  task automatic run64(input logic [1:0] sz, input logic un, input logic [31:0] addr,
                       input logic [63:0] rdat, output logic [7:0] be_s, output logic lv_s,
                       output logic [63:0] dout);
    @(negedge clk);
    rd64 = 1'b1; sz64 = sz; un64 = un; addr64 = addr; bus64.rdata = rdat; bus64.ack = 1'b0;
    @(posedge clk); #1;
    be_s = bus64.be;
    @(negedge clk);
    bus64.ack = 1'b1;
    @(posedge clk); #1;
    lv_s = lv64; dout = dout64;
    @(negedge clk);
    bus64.ack = 1'b0; rd64 = 1'b0;
  endtask

  task automatic test_dword64();
    logic [7:0] be; logic lv; logic [63:0] dout, rdat;
    rdat = {$urandom, $urandom};
    exp_q.push_back(rdat);
    run64(2'd3, 1, 32'h8, rdat, be, lv, dout);
    n_checks++; if (be !== 8'hFF) begin n_fail++; $display("FAIL d64_be: got %h expected ff", be); end
    n_checks++; if (lv !== 1'b1) begin n_fail++; $display("FAIL d64_valid: got %b expected 1", lv); end
    if (lv === 1'b1) begin
      exp_v = exp_q.pop_front();
      n_checks++; if (dout !== exp_v) begin n_fail++; $display("FAIL d64_data: got %h expected %h", dout, exp_v); end
    end
    exp_q.delete();
    exp_q.push_back(64'hFFFF_FFFF_8765_4321);
    run64(2'd2, 0, 32'h14, 64'h8765_4321_0000_0000, be, lv, dout);
    n_checks++; if (be !== 8'hF0) begin n_fail++; $display("FAIL w64_be: got %h expected f0", be); end
    if (lv === 1'b1) begin
      exp_v = exp_q.pop_front();
      n_checks++; if (dout !== exp_v) begin n_fail++; $display("FAIL w64_data: got %h expected %h", dout, exp_v); end
    end else begin
      n_checks++; n_fail++; $display("FAIL w64_valid: got 0 expected 1");
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    rd32 = 0; wr32 = 0; un32 = 0; sz32 = 0; addr32 = 0; wd32 = 0;
    bus32.ack = 0; bus32.rdata = 0;
    rd64 = 0; wr64 = 0; un64 = 0; sz64 = 0; addr64 = 0; wd64 = 0;
    bus64.ack = 0; bus64.rdata = 0;
    test_reset();
    test_load_byte();
    test_loads_random();
    test_store_half();
    test_misalign();
    test_timeout();
    test_rd_wr_both();
    test_reset_busy();
    test_dword64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
